// File: rtl/tag_rx_phase_sched_pkg.sv
// Shared constants for the tag receiver phase scheduler: register map,
// FSM encoding and power-on configuration values.
package tag_rx_phase_sched_pkg;

    localparam int SAMP_WIDTH = 16;

    localparam int OFF_NSIG         = 0;
    localparam int OFF_NSYMB        = 1;
    localparam int OFF_DPH_INC      = 2;
    localparam int OFF_START_PH_INC = 3;
    localparam int OFF_START_PH     = 4;
    localparam int OFF_NFRAMES      = 5;

    localparam int DEF_NSIG  = 1;
    localparam int DEF_NSYMB = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } sched_state_t;

endpackage

// File: rtl/tag_rx_phase_sched_if.sv
// AXI-Stream style phase port between the scheduler and the DDS tune path.
interface tag_rx_phase_sched_if #(
    parameter int PHASE_WIDTH = 24
) ();
    logic [PHASE_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tag_rx_phase_sched_regs.sv
// Settings-bus register bank; the live copy is writable at any time and the
// active copy is captured only when a run is accepted.
module tag_rx_sched_regs
    import tag_rx_phase_sched_pkg::*;
#(
    parameter int PHASE_WIDTH  = 24,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NFRAME_WIDTH = 16,
    parameter int SR_AWIDTH    = 8,
    parameter int SR_BASE      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_stb,
    input  logic [SR_AWIDTH-1:0]    set_addr,
    input  logic [31:0]             set_data,
    input  logic                    latch,
    output logic [SAMP_WIDTH-1:0]   live_nsig,
    output logic [NSYMB_WIDTH-1:0]  live_nsymb,
    output logic [PHASE_WIDTH-1:0]  live_start_ph_inc,
    output logic [PHASE_WIDTH-1:0]  live_start_ph,
    output logic [NFRAME_WIDTH-1:0] live_nframes,
    output logic [SAMP_WIDTH-1:0]   act_nsig,
    output logic [NSYMB_WIDTH-1:0]  act_nsymb,
    output logic [PHASE_WIDTH-1:0]  act_dph_inc,
    output logic [PHASE_WIDTH-1:0]  act_start_ph_inc,
    output logic [PHASE_WIDTH-1:0]  act_start_ph,
    output logic [NFRAME_WIDTH-1:0] act_nframes
);

    logic [PHASE_WIDTH-1:0] live_dph_inc;
    wire unused_set_data = &{1'b0, set_data};

    function automatic logic hit(input int off);
        return set_stb && (set_addr == SR_AWIDTH'(SR_BASE + off));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            live_nsig         <= SAMP_WIDTH'(DEF_NSIG);
            live_nsymb        <= NSYMB_WIDTH'(DEF_NSYMB);
            live_dph_inc      <= '0;
            live_start_ph_inc <= '0;
            live_start_ph     <= '0;
            live_nframes      <= '0;
        end else begin
            if (hit(OFF_NSIG))         live_nsig         <= set_data[SAMP_WIDTH-1:0];
            if (hit(OFF_NSYMB))        live_nsymb        <= set_data[NSYMB_WIDTH-1:0];
            if (hit(OFF_DPH_INC))      live_dph_inc      <= set_data[PHASE_WIDTH-1:0];
            if (hit(OFF_START_PH_INC)) live_start_ph_inc <= set_data[PHASE_WIDTH-1:0];
            if (hit(OFF_START_PH))     live_start_ph     <= set_data[PHASE_WIDTH-1:0];
            if (hit(OFF_NFRAMES))      live_nframes      <= set_data[NFRAME_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_nsig         <= SAMP_WIDTH'(DEF_NSIG);
            act_nsymb        <= NSYMB_WIDTH'(DEF_NSYMB);
            act_dph_inc      <= '0;
            act_start_ph_inc <= '0;
            act_start_ph     <= '0;
            act_nframes      <= '0;
        end else if (latch) begin
            act_nsig         <= live_nsig;
            act_nsymb        <= live_nsymb;
            act_dph_inc      <= live_dph_inc;
            act_start_ph_inc <= live_start_ph_inc;
            act_start_ph     <= live_start_ph;
            act_nframes      <= live_nframes;
        end
    end

endmodule

// File: rtl/tag_rx_phase_sched.sv
// Phase-sequence scheduler for the tag receiver DDS tune path.
//   state    | meaning
//   IDLE     | no stream; waits for start with a valid configuration
//   RUN      | streaming phase beats, frames repeat until count or stop
//   STOPPING | finishing the current symbol, then back to IDLE
module tag_rx_phase_sched
    import tag_rx_phase_sched_pkg::*;
#(
    parameter int PHASE_WIDTH  = 24,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NFRAME_WIDTH = 16,
    parameter int RX_SYNC_BITS = 4,
    parameter int SR_AWIDTH    = 8,
    parameter int SR_BASE      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_stb,
    input  logic [SR_AWIDTH-1:0]   set_addr,
    input  logic [31:0]            set_data,
    input  logic                   start,
    input  logic                   stop,
    tag_rx_phase_sched_if.master   phase,
    output logic                   busy,
    output logic [NSYMB_WIDTH-1:0] symb_idx,
    output logic                   frame_done,
    output logic                   sync_ready,
    output logic                   cfg_err
);

    logic [SAMP_WIDTH-1:0]   live_nsig, act_nsig;
    logic [NSYMB_WIDTH-1:0]  live_nsymb, act_nsymb;
    logic [PHASE_WIDTH-1:0]  live_start_ph_inc, live_start_ph;
    logic [PHASE_WIDTH-1:0]  act_dph_inc, act_start_ph_inc, act_start_ph;
    logic [NFRAME_WIDTH-1:0] live_nframes, act_nframes;

    sched_state_t            state_q, state_nxt;
    logic [PHASE_WIDTH-1:0]  phase_q, inc_q;
    logic [SAMP_WIDTH-1:0]   samp_left_q;
    logic [NSYMB_WIDTH-1:0]  symb_q;
    logic [NFRAME_WIDTH-1:0] frames_left_q;
    logic [RX_SYNC_BITS-1:0] sync_cnt_q;
    logic                    frame_done_q, cfg_err_q;
    logic                    run_act, hs, symb_end, frame_end, last_frame;
    logic                    cfg_bad, start_ok;

    tag_rx_sched_regs #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .NSYMB_WIDTH (NSYMB_WIDTH),
        .NFRAME_WIDTH(NFRAME_WIDTH),
        .SR_AWIDTH   (SR_AWIDTH),
        .SR_BASE     (SR_BASE)
    ) u_regs (
        .clk              (clk),
        .reset            (reset),
        .set_stb          (set_stb),
        .set_addr         (set_addr),
        .set_data         (set_data),
        .latch            (start_ok),
        .live_nsig        (live_nsig),
        .live_nsymb       (live_nsymb),
        .live_start_ph_inc(live_start_ph_inc),
        .live_start_ph    (live_start_ph),
        .live_nframes     (live_nframes),
        .act_nsig         (act_nsig),
        .act_nsymb        (act_nsymb),
        .act_dph_inc      (act_dph_inc),
        .act_start_ph_inc (act_start_ph_inc),
        .act_start_ph     (act_start_ph),
        .act_nframes      (act_nframes)
    );

    // samp_left_q counts down to zero at the symbol's last beat
    assign run_act    = (state_q != ST_IDLE);
    assign hs         = run_act && phase.tready;
    assign symb_end   = (samp_left_q == '0);
    assign frame_end  = symb_end && (symb_q >= act_nsymb);
    assign last_frame = (act_nframes != '0) && (frames_left_q == NFRAME_WIDTH'(1));
    assign cfg_bad    = (live_nsig == '0) || (live_nsymb == '0);
    assign start_ok   = (state_q == ST_IDLE) && start && !cfg_bad;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:     if (start_ok) state_nxt = ST_RUN;
            ST_RUN: begin
                if (hs && symb_end && (stop || (frame_end && last_frame)))
                    state_nxt = ST_IDLE;
                else if (stop)
                    state_nxt = ST_STOPPING;
            end
            ST_STOPPING: if (hs && symb_end) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        phase.tvalid = 1'b0;
        phase.tdata  = '0;
        phase.tlast  = 1'b0;
        busy         = 1'b0;
        if (run_act) begin
            phase.tvalid = 1'b1;
            phase.tdata  = phase_q;
            phase.tlast  = symb_end;
            busy         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= '0;
            inc_q         <= '0;
            samp_left_q   <= '0;
            symb_q        <= '0;
            frames_left_q <= '0;
            sync_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start && cfg_bad) begin
                    cfg_err_q <= 1'b1;
                end else if (start) begin
                    phase_q       <= live_start_ph;
                    inc_q         <= live_start_ph_inc;
                    samp_left_q   <= live_nsig - SAMP_WIDTH'(1);
                    symb_q        <= NSYMB_WIDTH'(1);
                    frames_left_q <= live_nframes;
                    sync_cnt_q    <= '0;
                end
            end else if (hs) begin
                if (!symb_end) begin
                    phase_q     <= phase_q + inc_q;
                    samp_left_q <= samp_left_q - SAMP_WIDTH'(1);
                end else begin
                    phase_q     <= act_start_ph;
                    samp_left_q <= act_nsig - SAMP_WIDTH'(1);
                    if (!frame_end) begin
                        inc_q <= inc_q + act_dph_inc;
                        if (state_nxt != ST_IDLE) symb_q <= symb_q + NSYMB_WIDTH'(1);
                    end else begin
                        inc_q        <= act_start_ph_inc;
                        frame_done_q <= 1'b1;
                        if (state_nxt != ST_IDLE) symb_q <= NSYMB_WIDTH'(1);
                        if (~&sync_cnt_q) sync_cnt_q <= sync_cnt_q + RX_SYNC_BITS'(1);
                        if (frames_left_q != '0) frames_left_q <= frames_left_q - NFRAME_WIDTH'(1);
                    end
                end
            end
        end
    end

    // symb_idx keeps the last streamed symbol once the run has ended
    assign symb_idx   = symb_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign sync_ready = &sync_cnt_q;

endmodule

// File: tb/tb_tag_rx_phase_sched.sv
// Directed bench for tag_rx_phase_sched: ramp, backpressure, wrap, stop,
// config error, sync saturation and mid-run reset.
module tb_tag_rx_phase_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, frame_done, sync_ready, cfg_err;
    logic [15:0] symb_idx;

    tag_rx_phase_sched_if #(.PHASE_WIDTH(24)) phase_if ();

    tag_rx_phase_sched #(
        .PHASE_WIDTH (24),
        .NSYMB_WIDTH (16),
        .NFRAME_WIDTH(16),
        .RX_SYNC_BITS(4),
        .SR_AWIDTH   (8),
        .SR_BASE     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .start     (start),
        .stop      (stop),
        .phase     (phase_if),
        .busy      (busy),
        .symb_idx  (symb_idx),
        .frame_done(frame_done),
        .sync_ready(sync_ready),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] got_d[$];
    logic        got_l[$];
    int          fd_cnt, stall_bad, first_cyc;
    logic        busy_end;
    logic [15:0] symb_end_v;

    task automatic write_reg(input int off, input logic [31:0] val);
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = 8'(off);
        set_data = val;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic cfg(input int nsig, input int nsymb, input int ph,
                       input int phinc, input int dph, input int nfr);
        write_reg(0, 32'(nsig));
        write_reg(1, 32'(nsymb));
        write_reg(2, 32'(dph));
        write_reg(3, 32'(phinc));
        write_reg(4, 32'(ph));
        write_reg(5, 32'(nfr));
    endtask

    // Pulses start, then collects accepted beats until tvalid falls.
    task automatic run_seq(input int rmode, input int stop_beat, input int max_cyc);
        logic        seen, done, have_prev, prev_l;
        logic [23:0] prev_d;
        int          cyc;
        got_d.delete();
        got_l.delete();
        fd_cnt = 0; stall_bad = 0; first_cyc = -1;
        seen = 0; done = 0; have_prev = 0; prev_d = '0; prev_l = 0; cyc = 0;
        busy_end = 1'bx; symb_end_v = 'x;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done && cyc < max_cyc) begin
            phase_if.tready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            stop = 1'b0;
            if (frame_done) fd_cnt++;
            if (phase_if.tvalid) begin
                if (!seen) first_cyc = cyc;
                seen = 1;
                if (have_prev && (phase_if.tdata !== prev_d || phase_if.tlast !== prev_l))
                    stall_bad++;
                if (phase_if.tready) begin
                    got_d.push_back(phase_if.tdata);
                    got_l.push_back(phase_if.tlast);
                    have_prev = 0;
                    if (got_d.size() == stop_beat) stop = 1'b1;
                end else begin
                    have_prev = 1;
                    prev_d = phase_if.tdata;
                    prev_l = phase_if.tlast;
                end
            end else if (seen) begin
                done = 1;
                busy_end = busy;
                symb_end_v = symb_idx;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        stop = 1'b0;
        phase_if.tready = 1'b1;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL run_timeout: no return to idle within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (phase_if.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", phase_if.tvalid); end
        tests++; if (phase_if.tdata !== 24'h0) begin fails++; $display("FAIL reset_tdata: got %h expected 000000", phase_if.tdata); end
        tests++; if (phase_if.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b expected 0", phase_if.tlast); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (symb_idx !== 16'h0) begin fails++; $display("FAIL reset_symb_idx: got %0d expected 0", symb_idx); end
        tests++; if ({frame_done, sync_ready, cfg_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {frame_done, sync_ready, cfg_err}); end
    endtask

    task automatic test_ramp(input int rmode, input string tag);
        logic [23:0] exp_d [12];
        exp_d = '{24'h000000, 24'h000100, 24'h000200, 24'h000300,
                  24'h000000, 24'h000110, 24'h000220, 24'h000330,
                  24'h000000, 24'h000120, 24'h000240, 24'h000360};
        cfg(4, 3, 0, 'h100, 'h10, 1);
        run_seq(rmode, 0, 200);
        tests++; if (got_d.size() != 12) begin fails++; $display("FAIL %s_beats: got %0d expected 12", tag, got_d.size()); end
        for (int i = 0; i < 12 && i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== exp_d[i]) begin fails++; $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, got_d[i], exp_d[i]); end
            tests++; if (got_l[i] !== (i % 4 == 3)) begin fails++; $display("FAIL %s_tlast[%0d]: got %b expected %b", tag, i, got_l[i], (i % 4 == 3)); end
        end
        tests++; if (first_cyc != 0) begin fails++; $display("FAIL %s_latency: first valid at %0d expected 0", tag, first_cyc); end
        tests++; if (fd_cnt != 1) begin fails++; $display("FAIL %s_frame_done: got %0d expected 1", tag, fd_cnt); end
        tests++; if (busy_end !== 1'b0) begin fails++; $display("FAIL %s_busy_end: got %b expected 0", tag, busy_end); end
        tests++; if (symb_end_v !== 16'd3) begin fails++; $display("FAIL %s_symb_idx: got %0d expected 3", tag, symb_end_v); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL %s_stall_stable: got %0d changes expected 0", tag, stall_bad); end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_d [3];
        exp_d = '{24'hFFFF00, 24'h000000, 24'h000100};
        cfg(3, 1, 'hFFFF00, 'h100, 0, 1);
        run_seq(0, 0, 100);
        tests++; if (got_d.size() != 3) begin fails++; $display("FAIL wrap_beats: got %0d expected 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== exp_d[i]) begin fails++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]); end
            tests++; if (got_l[i] !== (i == 2)) begin fails++; $display("FAIL wrap_tlast[%0d]: got %b expected %b", i, got_l[i], (i == 2)); end
        end
        tests++; if (fd_cnt != 1) begin fails++; $display("FAIL wrap_frame_done: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_stop();
        logic [23:0] exp_d [8];
        exp_d = '{24'h000000, 24'h000100, 24'h000200, 24'h000300,
                  24'h000000, 24'h000110, 24'h000220, 24'h000330};
        cfg(4, 3, 0, 'h100, 'h10, 0);
        run_seq(0, 6, 200);
        tests++; if (got_d.size() != 8) begin fails++; $display("FAIL stop_beats: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            tests++; if (got_d[i] !== exp_d[i]) begin fails++; $display("FAIL stop_data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]); end
            tests++; if (got_l[i] !== (i % 4 == 3)) begin fails++; $display("FAIL stop_tlast[%0d]: got %b expected %b", i, got_l[i], (i % 4 == 3)); end
        end
        tests++; if (fd_cnt != 0) begin fails++; $display("FAIL stop_frame_done: got %0d expected 0", fd_cnt); end
        tests++; if (busy_end !== 1'b0) begin fails++; $display("FAIL stop_busy_end: got %b expected 0", busy_end); end
        tests++; if (symb_end_v !== 16'd2) begin fails++; $display("FAIL stop_symb_idx: got %0d expected 2", symb_end_v); end
    endtask

    task automatic test_cfg_err();
        write_reg(0, 32'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err); end
        tests++; if (phase_if.tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL cfg_err_idle: tvalid %b busy %b expected 0 0", phase_if.tvalid, busy); end
        @(negedge clk);
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_width: got %b expected 0", cfg_err); end
        tests++; if (phase_if.tvalid !== 1'b0) begin fails++; $display("FAIL cfg_err_tvalid: got %b expected 0", phase_if.tvalid); end
    endtask

    task automatic test_sync();
        int fd, bad, cyc;
        cfg(1, 1, 'h123456, 'h55, 'h7, 0);
        fd = 0; bad = 0; cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (fd < 20 && cyc < 60) begin
            if (frame_done) fd++;
            if (sync_ready !== (fd >= 15)) bad++;
            if (phase_if.tvalid !== 1'b1 || phase_if.tdata !== 24'h123456 || phase_if.tlast !== 1'b1) bad++;
            if (fd < 20) begin @(negedge clk); cyc++; end
        end
        tests++; if (fd != 20) begin fails++; $display("FAIL sync_frames: got %0d expected 20", fd); end
        tests++; if (bad != 0) begin fails++; $display("FAIL sync_track: got %0d bad cycles expected 0", bad); end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        tests++; if (phase_if.tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sync_stop: tvalid %b busy %b expected 0 0", phase_if.tvalid, busy); end
        repeat (2) @(negedge clk);
        tests++; if (sync_ready !== 1'b1) begin fails++; $display("FAIL sync_hold: got %b expected 1", sync_ready); end
    endtask

    task automatic test_midrun_reset();
        cfg(4, 3, 'h5000, 'h100, 'h10, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (phase_if.tvalid !== 1'b0 || phase_if.tlast !== 1'b0 || phase_if.tdata !== 24'h0) begin fails++; $display("FAIL rst_stream: tvalid %b tlast %b tdata %h expected 0 0 000000", phase_if.tvalid, phase_if.tlast, phase_if.tdata); end
        tests++; if (busy !== 1'b0 || symb_idx !== 16'h0) begin fails++; $display("FAIL rst_status: busy %b symb_idx %0d expected 0 0", busy, symb_idx); end
        reset = 1'b0;
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        tests++; if (phase_if.tvalid !== 1'b1 || phase_if.tdata !== 24'h0 || phase_if.tlast !== 1'b1) begin fails++; $display("FAIL rst_default_beat: tvalid %b tdata %h tlast %b expected 1 000000 1", phase_if.tvalid, phase_if.tdata, phase_if.tlast); end
        tests++; if (symb_idx !== 16'd1) begin fails++; $display("FAIL rst_symb_idx: got %0d expected 1", symb_idx); end
        @(negedge clk);
        tests++; if (phase_if.tvalid !== 1'b1 || phase_if.tdata !== 24'h0) begin fails++; $display("FAIL rst_continuous: tvalid %b tdata %h expected 1 000000", phase_if.tvalid, phase_if.tdata); end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        tests++; if (phase_if.tvalid !== 1'b0) begin fails++; $display("FAIL rst_stop: tvalid %b expected 0", phase_if.tvalid); end
    endtask

    initial begin
        phase_if.tready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_ramp(0, "ramp");
        test_ramp(1, "bp");
        test_wrap();
        test_stop();
        test_cfg_err();
        test_sync();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
